// File: rtl/ras_stack.sv
// ras_stack -- return-address stack for jal/jalr target prediction.
//
// Holds a circular buffer of return addresses, a saturating occupancy
// count and the register number that currently aliases ra. Speculative
// pushes/pops made by instructions later flushed are undone with the
// rollback strobes; popped entries are never erased, so undoing a pop
// brings the old return address back.
//
// Optional feature: define RAS_STATS_EN to add saturating overflow /
// underflow event counters (ovf_cnt, udf_cnt).
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   ras_push, push_addr     push return address
//   ras_pop                 pop top entry
//   ras_rollback_pop_id     undo one push made by the instruction in ID
//   ras_rollback_push_id    undo one pop made by the instruction in ID
//   ras_rollback_push_ex    undo one pop made by the instruction in EX
//   WR_ra_track_en, Rd      load the ra-alias register with Rd
//   top_addr                predicted return address, mem[ptr-1]
//   top_valid               stack non-empty
//   ras_ra_track            register currently aliasing ra
//   ovf_cnt, udf_cnt        (RAS_STATS_EN only) event counters
//
// Strobe semantics: every input is a single-cycle strobe sampled on the
// rising clock edge; there is no back-pressure. Any rollback strobe wins
// over push/pop in the same cycle. All outputs are combinational from
// registered state, so an update shows the cycle after its strobe.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ras_push,
  input  logic [AW-1:0] push_addr,
  input  logic          ras_pop,
  input  logic          ras_rollback_pop_id,
  input  logic          ras_rollback_push_id,
  input  logic          ras_rollback_push_ex,
  input  logic          WR_ra_track_en,
  input  logic [4:0]    Rd,
`ifdef RAS_STATS_EN
  output logic [15:0]   ovf_cnt,
  output logic [15:0]   udf_cnt,
`endif
  output logic [AW-1:0] top_addr,
  output logic          top_valid,
  output logic [4:0]    ras_ra_track
);

  localparam int CW = PTR_W + 1;  // count spans 0..DEPTH
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       track_q, track_d;

  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [PTR_W-1:0] ptr_m1;
  logic             rollback;
  logic [1:0]       rb_inc;
  logic [CW:0]      cnt_rb;
  logic             ovf_evt, udf_evt;

  assign ptr_m1   = ptr_q - PTR_W'(1);
  assign rollback = ras_rollback_pop_id | ras_rollback_push_id | ras_rollback_push_ex;
  assign rb_inc   = {1'b0, ras_rollback_push_id} + {1'b0, ras_rollback_push_ex};

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    track_d = track_q;
    we      = 1'b0;
    waddr   = ptr_q;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    cnt_rb  = {1'b0, count_q} + (CW+1)'(rb_inc);

    if (rollback) begin
      // Net delta is -1..+2; ptr wraps modulo DEPTH, count clamps to 0..DEPTH.
      ptr_d = ptr_q + PTR_W'(rb_inc) - PTR_W'(ras_rollback_pop_id);
      if (ras_rollback_pop_id) begin
        cnt_rb = (cnt_rb == '0) ? '0 : cnt_rb - (CW+1)'(1);
      end
      count_d = (cnt_rb > (CW+1)'(DEPTH)) ? FULL : cnt_rb[CW-1:0];
    end else if (ras_push && ras_pop && count_q != '0) begin
      // Coroutine swap: replace the top entry in place.
      we    = 1'b1;
      waddr = ptr_m1;
    end else if (ras_push) begin
      // Full stack silently overwrites the oldest entry (slot at ptr).
      we      = 1'b1;
      ptr_d   = ptr_q + PTR_W'(1);
      count_d = (count_q == FULL) ? FULL : count_q + CW'(1);
      ovf_evt = (count_q == FULL);
    end else if (ras_pop) begin
      if (count_q != '0) begin
        ptr_d   = ptr_m1;
        count_d = count_q - CW'(1);
      end else begin
        udf_evt = 1'b1;
      end
    end

    if (!rollback) begin
      if (ras_push || ras_pop)  track_d = 5'd1;
      else if (WR_ra_track_en)  track_d = Rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      track_q <= 5'd1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      track_q <= track_d;
      if (we) mem_q[waddr] <= push_addr;
    end
  end

`ifdef RAS_STATS_EN
  logic [15:0] ovf_q, udf_q;

  // Statistics are observational only: rollbacks never undo them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      if (ovf_evt && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      if (udf_evt && udf_q != 16'hFFFF) udf_q <= udf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
  assign udf_cnt = udf_q;
`else
  logic unused_evt;
  assign unused_evt = ovf_evt ^ udf_evt;
`endif

  assign top_addr     = mem_q[ptr_m1];
  assign top_valid    = (count_q != '0);
  assign ras_ra_track = track_q;

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return-address stack (RAS) for jal/jalr target prediction in the fetch/ID path.
- Directly downstream of the hazard/RAS control logic: consumes its ras_push / ras_pop / ras_rollback_* / WR_ra_track_en strobes.
- Feeds it the tracked alias register ras_ra_track.
- Holds a circular buffer of return addresses, a saturating occupancy count, and the ra-alias tracking register; undoes speculative push/pop on pipeline flush.

Parameters:
- DEPTH, 8, number of stack entries; power of two, ≥2.
- AW, 32, return-address width in bits.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ras_push  in  1  push push_addr (jal/jalr with rd=ra, not flushed/stalled).
- push_addr  in  AW  return address to push (PC+4 of the jal/jalr).
- ras_pop  in  1  pop top entry (jalr through ra or tracked alias).
- ras_rollback_pop_id  in  1  undo one push made by the instruction in ID.
- ras_rollback_push_id  in  1  undo one pop made by the instruction in ID.
- ras_rollback_push_ex  in  1  undo one pop made by the instruction in EX.
- WR_ra_track_en  in  1  load alias register with Rd.
- Rd  in  5  destination register of the instruction copying ra.
- top_addr  out  AW  predicted return address, mem[ptr-1].
- top_valid  out  1  count != 0.
- ras_ra_track  out  5  register currently aliasing ra.

Behaviour:
- State: mem[DEPTH], ptr (next free slot, mod DEPTH), count (0..DEPTH), track (5 bits).
- Async reset: ptr=0, count=0, track=5'd1 (ra), mem cleared to 0. Outputs after reset: top_valid=0, top_addr=0, ras_ra_track=1.
- Outputs are combinational from registered state. Every update is visible the cycle after the strobe.
- Priority: any rollback strobe asserted → ras_push and ras_pop ignored that cycle.
- Rollback:
  - net delta d = rollback_push_id + rollback_push_ex − rollback_pop_id, range −1..+2.
  - ptr += d mod DEPTH.
  - count = clamp(count + d, 0, DEPTH).
  - mem unchanged: popped data is never erased, so undoing a pop restores the old entry.
- Push only:
  - mem[ptr] ← push_addr; ptr+1.
  - count = min(count+1, DEPTH).
  - Overflow at count=DEPTH silently overwrites the oldest entry.
- Pop only:
  - count>0: ptr−1, count−1.
  - count=0 (underflow): no state change.
- Push and pop together (coroutine swap, jalr rd=ra rs1=ra):
  - count>0: mem[ptr−1] ← push_addr; ptr and count unchanged.
  - count=0: behaves as push only.
- Alias tracking, evaluated in this order:
  - any rollback → track unchanged;
  - else push or pop → track ← 1;
  - else WR_ra_track_en → track ← Rd;
  - else hold.
- Wrap-around: ptr arithmetic is modulo DEPTH in both directions. top_addr indexes (ptr−1) mod DEPTH.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro RAS_STATS_EN.
- Defined: adds outputs ovf_cnt[15:0] and udf_cnt[15:0], saturating at 16'hFFFF, reset to 0.
  - ovf_cnt increments on every accepted push at count=DEPTH that is not a swap.
  - udf_cnt increments on every pop-only at count=0.
  - Counters are not rolled back.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset, then push 0x100, 0x104, 0x108 on consecutive cycles → top_addr=0x108, top_valid=1; three pops → top 0x104, 0x100, then top_valid=0.
- DEPTH=8: push 0x0..0x24 step 4 (10 pushes), then 8 pops → tops 0x24 down to 0x8; the 9th pop is an underflow, top_valid stays 0; with RAS_STATS_EN, ovf_cnt=2 and udf_cnt=1.
- Push 0xA0, 0xB0; pop (top→0xA0); rollback_push_id → top_addr=0xB0, count=2 restored.
- Push 0xA0; push+pop same cycle with 0xC0 → top=0xC0, count=1; rollback_pop_id + rollback_push_id same cycle → no change, top=0xC0.
- WR_ra_track_en=1, Rd=5 → ras_ra_track=5; next push → ras_ra_track=1; WR with rollback_push_ex → track unchanged, ptr+1.
- Assert rst_n low between clock edges while count=3 → top_valid=0 and ras_ra_track=1 before the next edge.
